nav_arb: RTL and testbench
==========================

NAV_ARB -- requirements
Module: nav_arb

Interface
REQ-001 SHALL have parameter N_SRC, default 2, number of move-command sources (legal 2..8).
REQ-002 SHALL have parameter HDNG_W, default 12, signed heading width.
REQ-003 SHALL have parameter TMO_CYC, default 24'h80_0000, busy-watchdog limit in clk cycles.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port src_sel  in  SEL_W=$clog2(N_SRC)  requested owning source.
REQ-007 SHALL have port src_hdng  in  N_SRC*HDNG_W  packed desired headings, source i at [i*HDNG_W +: HDNG_W].
REQ-008 SHALL have port src_strt_hdng  in  N_SRC  per-source start-heading pulse.
REQ-009 SHALL have port src_strt_mv  in  N_SRC  per-source start-move pulse.
REQ-010 SHALL have port src_stp_lft, src_stp_rght  in  N_SRC each  per-source stop-at-opening flags.
REQ-011 SHALL have port src_cmplt  out  N_SRC  one-cycle completion pulse to owning source.
REQ-012 SHALL have port src_rej  out  N_SRC  one-cycle reject pulse per source.
REQ-013 SHALL have port dsrd_hdng  out  HDNG_W  registered heading to navigate/IR_math.
REQ-014 SHALL have port strt_hdng, strt_mv  out  1 each  one-cycle start pulses to navigate.
REQ-015 SHALL have port stp_lft, stp_rght  out  1 each  latched stop flags to navigate.
REQ-016 SHALL have port mv_cmplt  in  1  completion pulse from navigate.
REQ-017 SHALL have port owner  out  SEL_W; busy  out  1; tmo  out  1 (one-cycle watchdog abort pulse).

Function
REQ-018 SHALL implement states IDLE, HDNG, MOVE; busy = (state != IDLE).
REQ-019 SHALL, in IDLE, accept requests only from source owner; requests from any other source SHALL pulse its src_rej next cycle.
REQ-020 SHALL, on accepted src_strt_hdng, capture that source's heading into dsrd_hdng, pulse strt_hdng next cycle (latency 1), enter HDNG.
REQ-021 SHALL, on accepted src_strt_mv, latch stp_lft/stp_rght from that source, pulse strt_mv next cycle, enter MOVE; dsrd_hdng unchanged.
REQ-022 SHALL, if owner asserts strt_hdng and strt_mv same cycle, accept strt_hdng only and pulse owner's src_rej.
REQ-023 SHALL, in HDNG/MOVE, reject (src_rej) every new request including the owner's.
REQ-024 SHALL, on mv_cmplt in HDNG/MOVE, pulse src_cmplt[owner] next cycle and return to IDLE; stp_lft/stp_rght clear to 0 on that transition.
REQ-025 SHALL ignore mv_cmplt in IDLE (no src_cmplt, no state change).
REQ-026 SHALL load owner from src_sel only in IDLE; a src_sel change while busy takes effect the cycle after return to IDLE.
REQ-027 SHALL treat src_sel >= N_SRC as "no owner": all requests rejected, owner holds last legal value.
REQ-028 SHALL hold dsrd_hdng between commands (no return to 0 on completion).

Reset
REQ-029 SHALL, with rst high at a clock edge, force IDLE, owner=0, dsrd_hdng=0, all pulses/flags=0, watchdog count=0.
REQ-030 SHALL, on rst mid-HDNG/MOVE, abort silently: no src_cmplt, no tmo.

Configuration
REQ-031 SHALL, with NAV_ARB_WDOG_EN defined, count cycles in HDNG/MOVE; on reaching TMO_CYC pulse tmo and src_cmplt[owner] same cycle, return to IDLE.
REQ-032 SHALL, without NAV_ARB_WDOG_EN, omit the counter; tmo tied 0; busy persists until mv_cmplt.

Structure
REQ-033 SHALL place state enum nav_arb_state_t and default HDNG_W/TMO_CYC constants in package nav_arb_pkg.
REQ-034 SHALL place the watchdog counter in sub-module nav_arb_wdog (clr, en, expired), instantiated only under NAV_ARB_WDOG_EN.

Verification
REQ-035 SHALL cover: src_sel=1, src1 strt_hdng with hdng 12'h3FF -> next cycle strt_hdng=1, dsrd_hdng=12'h3FF, busy=1; mv_cmplt -> src_cmplt=2'b10.
REQ-036 SHALL cover: src_sel=0, src1 strt_mv -> src_rej=2'b10, strt_mv stays 0, state IDLE.
REQ-037 SHALL cover: in MOVE, src_sel 0->1 -> owner stays 0 until mv_cmplt, then owner=1 one cycle after IDLE.
REQ-038 SHALL cover: owner strt_hdng+strt_mv same cycle -> strt_hdng pulse only, src_rej[owner]=1.
REQ-039 SHALL cover: NAV_ARB_WDOG_EN, TMO_CYC=16, no mv_cmplt -> tmo and src_cmplt pulse exactly 16 cycles after strt_mv; rst mid-MOVE -> no pulses, outputs 0.

Source files
------------

// File: rtl/nav_arb_pkg.sv
// Shared types and default constants for the navigation command arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nav_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDNG = 2'd1,
        ST_MOVE = 2'd2
    } nav_arb_state_t;

    localparam int          NAV_ARB_HDNG_W  = 12;
    localparam logic [23:0] NAV_ARB_TMO_CYC = 24'h80_0000;

endpackage

// File: rtl/nav_arb_wdog.sv
// Busy watchdog: counts enabled cycles and flags the cycle the limit is reached.
// Latency: expired is combinational from the count; it is high in the TMO_CYC-th enabled cycle.
// Backpressure: none; clr has priority over en.
module nav_arb_wdog
    import nav_arb_pkg::*;
#(
    parameter logic [23:0] TMO_CYC = NAV_ARB_TMO_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [23:0] cnt;

    // Count busy cycles; cleared whenever the arbiter sits idle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 24'd1;
        end
    end

    assign expired = en && (cnt == (TMO_CYC - 24'd1));

endmodule

// File: rtl/nav_arb.sv
// Arbitrates heading/move commands from N_SRC sources onto one navigate engine (optional watchdog: NAV_ARB_WDOG_EN).
// Latency: 1 cycle from accepted request to strt_hdng/strt_mv, and from mv_cmplt to src_cmplt.
// Backpressure: none; requests that cannot be taken are dropped with a one-cycle src_rej pulse.
module nav_arb
    import nav_arb_pkg::*;
#(
    parameter int          N_SRC   = 2,
    parameter int          HDNG_W  = NAV_ARB_HDNG_W,
    parameter logic [23:0] TMO_CYC = NAV_ARB_TMO_CYC,
    localparam int         SEL_W   = $clog2(N_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [N_SRC*HDNG_W-1:0]  src_hdng,
    input  logic [N_SRC-1:0]         src_strt_hdng,
    input  logic [N_SRC-1:0]         src_strt_mv,
    input  logic [N_SRC-1:0]         src_stp_lft,
    input  logic [N_SRC-1:0]         src_stp_rght,
    output logic [N_SRC-1:0]         src_cmplt,
    output logic [N_SRC-1:0]         src_rej,
    output logic [HDNG_W-1:0]        dsrd_hdng,
    output logic                     strt_hdng,
    output logic                     strt_mv,
    output logic                     stp_lft,
    output logic                     stp_rght,
    input  logic                     mv_cmplt,
    output logic [SEL_W-1:0]         owner,
    output logic                     busy,
    output logic                     tmo
);

    localparam logic [SEL_W:0] N_SRC_L = N_SRC[SEL_W:0];

    nav_arb_state_t      state;
    logic                owner_vld;
    logic                idle;
    logic [N_SRC-1:0]    own_oh;
    logic [HDNG_W-1:0]   own_hdng;
    logic                own_req_h;
    logic                own_req_m;
    logic                own_stp_l;
    logic                own_stp_r;
    logic                acc_hdng;
    logic                acc_mv;
    logic [N_SRC-1:0]    rej_nxt;
    logic                wdog_exp;

    // Select the current owner's request fields and decide accept/reject.
    always_comb begin
        own_oh    = '0;
        own_hdng  = '0;
        own_req_h = 1'b0;
        own_req_m = 1'b0;
        own_stp_l = 1'b0;
        own_stp_r = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (owner == i[SEL_W-1:0]) begin
                own_oh[i] = 1'b1;
                own_hdng  = src_hdng[i*HDNG_W +: HDNG_W];
                own_req_h = src_strt_hdng[i];
                own_req_m = src_strt_mv[i];
                own_stp_l = src_stp_lft[i];
                own_stp_r = src_stp_rght[i];
            end
        end
        idle     = (state == ST_IDLE);
        acc_hdng = idle && owner_vld && own_req_h;
        // Heading wins when the owner asks for both in the same cycle.
        acc_mv   = idle && owner_vld && own_req_m && !own_req_h;
        rej_nxt  = src_strt_hdng | src_strt_mv;
        if (acc_mv || (acc_hdng && !own_req_m)) begin
            rej_nxt = rej_nxt & ~own_oh;
        end
    end

`ifdef NAV_ARB_WDOG_EN
    nav_arb_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (idle),
        .en      (!idle),
        .expired (wdog_exp)
    );

    // Abort pulse; a real completion in the same cycle takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo <= 1'b0;
        end else begin
            tmo <= wdog_exp && !mv_cmplt;
        end
    end
`else
    assign wdog_exp = 1'b0;
    assign tmo      = 1'b0;
`endif

    // Main FSM: owner tracking, command launch, completion and reject pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            owner_vld <= 1'b1;
            dsrd_hdng <= '0;
            strt_hdng <= 1'b0;
            strt_mv   <= 1'b0;
            stp_lft   <= 1'b0;
            stp_rght  <= 1'b0;
            src_cmplt <= '0;
            src_rej   <= '0;
        end else begin
            strt_hdng <= acc_hdng;
            strt_mv   <= acc_mv;
            src_rej   <= rej_nxt;
            src_cmplt <= '0;
            case (state)
                ST_IDLE: begin
                    if (acc_hdng) begin
                        dsrd_hdng <= own_hdng;
                        state     <= ST_HDNG;
                    end else if (acc_mv) begin
                        stp_lft   <= own_stp_l;
                        stp_rght  <= own_stp_r;
                        state     <= ST_MOVE;
                    end else if ({1'b0, src_sel} < N_SRC_L) begin
                        // Owner only follows src_sel while nothing is launching,
                        // so completion always returns to the launching source.
                        owner     <= src_sel;
                        owner_vld <= 1'b1;
                    end else begin
                        owner_vld <= 1'b0;
                    end
                end
                default: begin
                    if (mv_cmplt || wdog_exp) begin
                        src_cmplt <= own_oh;
                        stp_lft   <= 1'b0;
                        stp_rght  <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_nav_arb.sv
// Directed self-checking bench for nav_arb (N_SRC=2, HDNG_W=12, TMO_CYC=16).
module tb_nav_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  src_sel;
    logic [23:0] src_hdng;
    logic [1:0]  src_strt_hdng;
    logic [1:0]  src_strt_mv;
    logic [1:0]  src_stp_lft;
    logic [1:0]  src_stp_rght;
    logic [1:0]  src_cmplt;
    logic [1:0]  src_rej;
    logic [11:0] dsrd_hdng;
    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic        mv_cmplt;
    logic [0:0]  owner;
    logic        busy;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nav_arb #(
        .N_SRC   (2),
        .HDNG_W  (12),
        .TMO_CYC (24'd16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_sel       (src_sel),
        .src_hdng      (src_hdng),
        .src_strt_hdng (src_strt_hdng),
        .src_strt_mv   (src_strt_mv),
        .src_stp_lft   (src_stp_lft),
        .src_stp_rght  (src_stp_rght),
        .src_cmplt     (src_cmplt),
        .src_rej       (src_rej),
        .dsrd_hdng     (dsrd_hdng),
        .strt_hdng     (strt_hdng),
        .strt_mv       (strt_mv),
        .stp_lft       (stp_lft),
        .stp_rght      (stp_rght),
        .mv_cmplt      (mv_cmplt),
        .owner         (owner),
        .busy          (busy),
        .tmo           (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        src_strt_hdng = '0;
        src_strt_mv   = '0;
        src_stp_lft   = '0;
        src_stp_rght  = '0;
        mv_cmplt      = 1'b0;
    endtask

    logic [1:0] seen_cmplt;
    logic       seen_tmo;

    initial begin
        rst      = 1'b1;
        src_sel  = 1'b0;
        src_hdng = {12'h3FF, 12'h123};
        clr_req();
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_owner", 32'(owner),     32'h0);
        chk("rst_hdng",  32'(dsrd_hdng), 32'h0);
        chk("rst_pulse", 32'({strt_hdng, strt_mv, stp_lft, stp_rght, src_cmplt, src_rej}), 32'h0);
        chk("rst_tmo",   32'(tmo),       32'h0);

        // Source 1 heading command
        src_sel = 1'b1;
        step();
        chk("a_owner", 32'(owner), 32'h1);
        src_strt_hdng = 2'b10;
        step();
        clr_req();
        chk("a_strt_hdng", 32'(strt_hdng), 32'h1);
        chk("a_dsrd",      32'(dsrd_hdng), 32'h3FF);
        chk("a_busy",      32'(busy),      32'h1);
        chk("a_rej",       32'(src_rej),   32'h0);
        step();
        chk("a_pulse_end", 32'(strt_hdng), 32'h0);
        mv_cmplt = 1'b1;
        step();
        clr_req();
        chk("a_cmplt", 32'(src_cmplt), 32'h2);
        chk("a_idle",  32'(busy),      32'h0);
        step();
        chk("a_cmplt_end", 32'(src_cmplt), 32'h0);
        chk("a_hdng_hold", 32'(dsrd_hdng), 32'h3FF);

        // Completion while idle is ignored
        mv_cmplt = 1'b1;
        step();
        clr_req();
        chk("idle_cmplt", 32'(src_cmplt), 32'h0);
        chk("idle_busy",  32'(busy),      32'h0);

        // Non-owner move is rejected
        src_sel = 1'b0;
        step();
        src_strt_mv = 2'b10;
        src_stp_lft = 2'b10;
        step();
        clr_req();
        chk("b_rej",     32'(src_rej), 32'h2);
        chk("b_strt_mv", 32'(strt_mv), 32'h0);
        chk("b_busy",    32'(busy),    32'h0);
        chk("b_stp",     32'(stp_lft), 32'h0);

        // Owner 0 move; owner change deferred while busy
        src_strt_mv = 2'b01;
        src_stp_lft = 2'b01;
        src_stp_rght = 2'b10;
        step();
        clr_req();
        chk("c_strt_mv", 32'(strt_mv),   32'h1);
        chk("c_busy",    32'(busy),      32'h1);
        chk("c_stp",     32'({stp_lft, stp_rght}), 32'h2);
        chk("c_hdng",    32'(dsrd_hdng), 32'h3FF);
        src_sel = 1'b1;
        step();
        chk("c_owner_hold", 32'(owner), 32'h0);
        src_strt_hdng = 2'b01;
        step();
        clr_req();
        chk("c_busy_rej", 32'(src_rej),   32'h1);
        chk("c_no_start", 32'(strt_hdng), 32'h0);
        mv_cmplt = 1'b1;
        step();
        clr_req();
        chk("c_cmplt",     32'(src_cmplt), 32'h1);
        chk("c_idle",      32'(busy),      32'h0);
        chk("c_stp_clr",   32'({stp_lft, stp_rght}), 32'h0);
        chk("c_owner_old", 32'(owner),     32'h0);
        step();
        chk("c_owner_new", 32'(owner), 32'h1);

        // Owner asks for heading and move together
        src_hdng = {12'h800, 12'h123};
        src_strt_hdng = 2'b10;
        src_strt_mv   = 2'b10;
        step();
        clr_req();
        chk("d_strt_hdng", 32'(strt_hdng), 32'h1);
        chk("d_strt_mv",   32'(strt_mv),   32'h0);
        chk("d_rej",       32'(src_rej),   32'h2);
        chk("d_dsrd",      32'(dsrd_hdng), 32'h800);
        mv_cmplt = 1'b1;
        step();
        clr_req();
        chk("d_cmplt", 32'(src_cmplt), 32'h2);

        // Move with no completion: watchdog behaviour
        src_sel = 1'b0;
        step();
        src_strt_mv = 2'b01;
        step();
        clr_req();
        chk("e_strt_mv", 32'(strt_mv), 32'h1);
        seen_cmplt = '0;
        seen_tmo   = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            seen_cmplt = seen_cmplt | src_cmplt;
            seen_tmo   = seen_tmo | tmo;
        end
        chk("e_early", 32'({seen_tmo, seen_cmplt}), 32'h0);
        chk("e_busy15", 32'(busy), 32'h1);
        step();
`ifdef NAV_ARB_WDOG_EN
        chk("e_tmo",   32'(tmo),       32'h1);
        chk("e_cmplt", 32'(src_cmplt), 32'h1);
        chk("e_idle",  32'(busy),      32'h0);
        step();
        chk("e_tmo_end", 32'(tmo), 32'h0);
`else
        chk("e_tmo",   32'(tmo),       32'h0);
        chk("e_cmplt", 32'(src_cmplt), 32'h0);
        chk("e_busy",  32'(busy),      32'h1);
        mv_cmplt = 1'b1;
        step();
        clr_req();
        chk("e_cmplt_mv", 32'(src_cmplt), 32'h1);
`endif

        // Reset in the middle of a move aborts silently
        step();
        src_strt_mv  = 2'b01;
        src_stp_rght = 2'b01;
        step();
        clr_req();
        chk("f_stp", 32'(stp_rght), 32'h1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("f_busy", 32'(busy), 32'h0);
        chk("f_outs", 32'({strt_hdng, strt_mv, stp_lft, stp_rght, src_cmplt, src_rej, tmo}), 32'h0);
        chk("f_hdng", 32'(dsrd_hdng), 32'h0);
        chk("f_owner", 32'(owner), 32'h0);
        seen_cmplt = '0;
        seen_tmo   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            seen_cmplt = seen_cmplt | src_cmplt;
            seen_tmo   = seen_tmo | tmo;
        end
        chk("f_quiet", 32'({seen_tmo, seen_cmplt}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
